// File: rtl/ms_mul_arbiter_if.sv
// Requester-side bus of ms_mul_arbiter: operand request and product response
// handshakes, one lane per requester.
interface ms_mul_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [2*DW-1:0]    rsp_product;
   logic               rsp_err;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_product, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_product, rsp_err
   );
endinterface

// File: rtl/ms_mul_arbiter.sv
// Round-robin sequencer sharing one shift-add multiplier among NREQ requesters.
// Optional RUN timeout abort enabled by defining MS_ARB_TIMEOUT_EN.
module ms_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 2*DW+4
) (
   input  logic            clk,
   input  logic            rst,
   ms_mul_arbiter_if.slave bus,
   output logic            mul_clr_n,
   output logic            mul_ls,
   output logic [DW-1:0]   mul_a,
   output logic [DW-1:0]   mul_b,
   input  logic            mul_done,
   input  logic [2*DW-1:0] mul_product
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   if (NREQ < 2 || NREQ > 8 || DW < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("ms_mul_arbiter: unsupported parameter set");
   end

   logic [2:0]      state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   win_q, win_d;
   logic [PW-1:0]   gnt, idx;
   logic            found;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [2*DW-1:0] prod_q, prod_d;

`ifdef MS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT+1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   // First valid requester at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr_q) + k) % NREQ);
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
`ifdef MS_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               win_d   = gnt;
               a_d     = bus.req_a[int'(gnt)*DW +: DW];
               b_d     = bus.req_b[int'(gnt)*DW +: DW];
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: state_d = S_LOAD;
         S_LOAD: begin
            state_d = S_RUN;
`ifdef MS_ARB_TIMEOUT_EN
            cnt_d   = '0;
            err_d   = 1'b0;
`endif
         end
         S_RUN: begin
            if (mul_done) begin
               prod_d  = mul_product;
               state_d = S_RESP;
`ifdef MS_ARB_TIMEOUT_EN
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         S_RESP: begin
            if (bus.rsp_ready[win_q]) begin
               state_d = S_IDLE;
               ptr_d   = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
      end
   end

`ifdef MS_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   // Grant is combinational in IDLE; held off while reset is asserted.
   assign bus.req_ready = (state_q == S_IDLE && found && rst)
                        ? (NREQ'(1) << gnt) : '0;
   assign bus.rsp_valid = (state_q == S_RESP)
                        ? (NREQ'(1) << win_q) : '0;
   assign bus.rsp_product = prod_q;

   assign mul_clr_n = (state_q != S_CLEAR);
   assign mul_ls    = (state_q == S_LOAD);
   assign mul_a     = a_q;
   assign mul_b     = b_q;
endmodule
